// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C read-only slave: FSM states,
// SDA mux select codes and the fixed target address.
package i2c_pkg;

   typedef enum logic [3:0] {
      IDLE       = 4'd0,
      RX_ADDR    = 4'd1,
      CHECK_ADDR = 4'd2,
      ACK_ADDR   = 4'd3,
      NACK_ADDR  = 4'd4,
      LOAD       = 4'd5,
      SEND       = 4'd6,
      WAIT_ACK   = 4'd7,
      CHECK_MACK = 4'd8,
      WAIT_DONE  = 4'd9,
      DRAIN      = 4'd10
   } state_t;

   // SDA mux: release, drive 0, drive 1, drive tx shifter bit
   typedef enum logic [1:0] {
      SDA_IDLE = 2'b00,
      SDA_ACK  = 2'b01,
      SDA_NACK = 2'b10,
      SDA_TX   = 2'b11
   } sda_mode_t;

   localparam logic [6:0] SLAVE_ADDR = 7'b1111000;

endpackage

// File: rtl/i2c_slave_controller.sv
// Main FSM of the read-only I2C slave: sequences address check, ACK/NACK,
// FIFO pops and byte transmission for one transaction at a time.
module i2c_slave_controller
   import i2c_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_found,
   input  logic             stop_found,
   input  logic             address_match,
   input  logic             rw_mode,
   input  logic             byte_received,
   input  logic             ack_prep,
   input  logic             check_ack,
   input  logic             ack_done,
   input  logic             sda_in,
   input  logic             tx_empty,
   output logic             rx_enable,
   output logic             timer_active,
   output logic             load_data,
   output logic             read_enable,
   output logic             tx_enable,
   output logic [1:0]       sda_mode,
   output logic             busy,
   output logic [CNT_W-1:0] byte_count
);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] byte_count_reg, byte_count_next;
   sda_mode_t        sda_sel;

   // ack_prep only matters to the timer; the FSM advances on check_ack instead
   logic unused_inputs;
   assign unused_inputs = ack_prep;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         byte_count_reg <= '0;
      end else begin
         state_reg      <= state_next;
         byte_count_reg <= byte_count_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      byte_count_next = byte_count_reg;
      if (stop_found) begin
         state_next = IDLE;
      end else if (start_found) begin
         state_next      = RX_ADDR;
         byte_count_next = '0;
      end else begin
         case (state_reg)
            IDLE:       ;
            RX_ADDR:    if (byte_received) state_next = CHECK_ADDR;
            CHECK_ADDR: state_next = (address_match && rw_mode && !tx_empty) ? ACK_ADDR : NACK_ADDR;
            ACK_ADDR:   if (ack_done) state_next = LOAD;
            NACK_ADDR:  if (ack_done) state_next = IDLE;
            LOAD:       state_next = SEND;
            SEND:       if (byte_received) state_next = WAIT_ACK;
            WAIT_ACK:   if (check_ack) state_next = CHECK_MACK;
            CHECK_MACK: begin
               if (!sda_in) begin
                  state_next = WAIT_DONE;
                  if (byte_count_reg != {CNT_W{1'b1}})
                     byte_count_next = byte_count_reg + 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
            WAIT_DONE:  if (ack_done) state_next = tx_empty ? DRAIN : LOAD;
            DRAIN:      ;
            default:    state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      rx_enable    = 1'b0;
      timer_active = (state_reg != IDLE);
      load_data    = 1'b0;
      read_enable  = 1'b0;
      tx_enable    = 1'b0;
      sda_sel      = SDA_IDLE;
      case (state_reg)
         RX_ADDR:   rx_enable = 1'b1;
         ACK_ADDR:  sda_sel = SDA_ACK;
         NACK_ADDR: sda_sel = SDA_NACK;
         LOAD: begin
            load_data   = 1'b1;
            read_enable = 1'b1;
            sda_sel     = SDA_TX;
         end
         SEND: begin
            tx_enable = 1'b1;
            sda_sel   = SDA_TX;
         end
         DRAIN:     sda_sel = SDA_NACK;
         default:   ;
      endcase
   end

   assign sda_mode   = sda_sel;
   assign busy       = (state_reg != IDLE);
   assign byte_count = byte_count_reg;

endmodule

// File: doc/i2c_slave_controller.md
Name: i2c_slave_controller

Overview:
- Main FSM of the I2C slave (read-only target, 7-bit address 7'b1111000).
- Consumes the start/stop, address_match and rw_mode flags from the bus decode stage and the bit-timing flags from the SCL timer.
- Sequences the rx shifter, tx shifter, tx FIFO read port and SDA output mux for one transaction at a time.
- Sits between the decode/timer blocks and the shift registers/FIFO.

Parameters:
- CNT_W, 8, width of the transaction byte counter (byte_count), saturating.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start_found  in  1  start or repeated start detected (1-cycle pulse from decode)
- stop_found  in  1  stop detected (1-cycle pulse from decode)
- address_match  in  1  received address byte [7:1] == 7'b1111000
- rw_mode  in  1  received address byte bit 0 (1 = master read)
- byte_received  in  1  timer pulse: 8th data bit clocked
- ack_prep  in  1  timer pulse: SCL low before the 9th (ACK) bit
- check_ack  in  1  timer pulse: SCL high on the ACK bit
- ack_done  in  1  timer pulse: SCL falling after the ACK bit
- sda_in  in  1  synchronized SDA
- tx_empty  in  1  tx FIFO empty
- rx_enable  out  1  rx shifter shift enable
- timer_active  out  1  SCL timer running
- load_data  out  1  load tx shifter from FIFO (1-cycle pulse)
- read_enable  out  1  FIFO pop (1-cycle pulse, same cycle as load_data)
- tx_enable  out  1  tx shifter shift enable
- sda_mode  out  2  SDA mux select (see package)
- busy  out  1  high in every state except IDLE
- byte_count  out  CNT_W  bytes ACKed by master in the current transaction

Behaviour:
- Moore FSM; all outputs decode from the registered state except byte_count, which is a register.
- Reset (rst=1 at a clk edge): state IDLE, byte_count 0, all outputs 0, sda_mode IDLE. Reset mid-transaction aborts immediately; the next cycle is IDLE.
- Global priority, evaluated every cycle: rst > stop_found (to IDLE) > start_found (to RX_ADDR, byte_count cleared) > per-state transition. This covers repeated starts in any state.
- IDLE: all outputs 0. start_found -> RX_ADDR.
- RX_ADDR: rx_enable=1, timer_active=1. byte_received -> CHECK_ADDR.
- CHECK_ADDR: timer_active=1, one cycle only.
  - address_match && rw_mode && !tx_empty -> ACK_ADDR.
  - Otherwise -> NACK_ADDR.
- ACK_ADDR: sda_mode=ACK, timer_active=1. ack_done -> LOAD.
- NACK_ADDR: sda_mode=NACK, timer_active=1. ack_done -> IDLE.
- LOAD: load_data=1, read_enable=1, timer_active=1, sda_mode=TX; one cycle -> SEND.
- SEND: tx_enable=1, timer_active=1, sda_mode=TX. byte_received -> WAIT_ACK.
- WAIT_ACK: sda_mode=IDLE (released), timer_active=1. check_ack -> CHECK_MACK.
- CHECK_MACK: timer_active=1, one cycle; samples sda_in.
  - sda_in=0 (master ACK): byte_count += 1, saturating at 2^CNT_W-1; -> WAIT_DONE.
  - sda_in=1 (master NACK): -> IDLE.
- WAIT_DONE: timer_active=1. On ack_done:
  - !tx_empty -> LOAD.
  - tx_empty -> DRAIN.
- DRAIN: sda_mode=NACK (drives 1, i.e. 0xFF bytes); timer_active=1; stays until stop/start. read_enable is never asserted on an empty FIFO.
- Latency: a flag pulse in cycle N changes the state, and therefore the outputs, in cycle N+1.
- Pulses that are irrelevant to the current state are ignored.
- byte_count holds its value in IDLE until the next start clears it.

Decomposition:
- Package i2c_pkg:
  - state_t enum: IDLE, RX_ADDR, CHECK_ADDR, ACK_ADDR, NACK_ADDR, LOAD, SEND, WAIT_ACK, CHECK_MACK, WAIT_DONE, DRAIN.
  - sda_mode_t: 2'b00 IDLE/release, 2'b01 ACK (drive 0), 2'b10 NACK (drive 1), 2'b11 TX (drive shifter bit).
  - SLAVE_ADDR = 7'b1111000.
- No sub-module is needed; next-state and output decode are two always blocks in one module.

Test Plan:
- rst held 2 cycles mid-SEND -> next cycle: state IDLE, every output 0, byte_count 0.
- start; byte_received with address_match=1, rw_mode=1, tx_empty=0 -> CHECK_ADDR for 1 cycle, then sda_mode=01; ack_done -> load_data=read_enable=1 for exactly 1 cycle, then tx_enable=1, sda_mode=11.
- Address 0x50 (address_match=0) -> sda_mode=10 until ack_done, then IDLE, busy=0.
- Master ACK on 3 bytes, then sda_in=1 at check_ack on the 4th -> byte_count=3, IDLE; FIFO pops=4.
- tx_empty=1 at WAIT_DONE after byte 1 -> DRAIN with sda_mode=10, no read_enable; stop_found -> IDLE in 1 cycle.
- Repeated start during SEND -> RX_ADDR next cycle, byte_count=0, tx_enable=0. Simultaneous start_found and stop_found -> IDLE.
